glyph_fetch_sequencer: RTL and testbench

- Per-scanline fetch controller for the VGA clock display.
- On each text-row line start, it walks SLOTS character slots (digits, AM/PM, 24H, colour tags). For each slot it drives the 4-bit glyph code into the glyph pointer table and turns the returned base row and chip select into a ROM row address.
- It fetches the 8-bit row bitmap over a req/ack handshake and queues it in a 2-entry buffer for the pixel generator.

---
 rtl/glyph_fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_glyph_fetch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_fetch_sequencer.sv
// rtl/glyph_fetch_sequencer.sv - per-scanline glyph row fetch controller with 2-entry output buffer
module glyph_fetch_sequencer #(
   parameter int SLOTS  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              slot_we,
   input  logic [2:0]        slot_idx,
   input  logic [3:0]        slot_code,
   input  logic              line_start,
   input  logic [5:0]        glyph_row,
   output logic [3:0]        value_out,
   input  logic [ADDR_W-1:0] point_y,
   input  logic [1:0]        chip_sel,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [1:0]        rom_cs,
   input  logic              rom_ack,
   input  logic [7:0]        rom_data,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic [2:0]        out_slot,
   input  logic              out_ready,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REQ, S_PUSH} state_t;

   state_t            r_state;
   logic [3:0]        r_code [0:7];
   logic [2:0]        r_slot;
   logic [5:0]        r_row;
   logic [7:0]        r_data;
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_cs;
   logic              r_busy;
   logic              r_overrun;
   logic [10:0]       r_mem [0:1];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;

   logic              w_blank;
   logic              w_last;
   logic              w_pop;
   logic              w_push;
   logic [ADDR_W-1:0] w_addr;

   // The pointer table is combinational on value_out, so the code is only presented during LOOKUP
   assign value_out = (r_state == S_LOOKUP) ? r_code[r_slot] : 4'd0;

   // Blank glyph, indicator row outside its 20-row height, or row past the glyph bottom: no ROM access
   assign w_blank = (chip_sel == 2'b00) || (chip_sel[1] && (r_row >= 6'd20)) || (r_row >= 6'd60);
   assign w_last  = (r_slot == 3'(SLOTS - 1));
   assign w_addr  = point_y + ADDR_W'(r_row);

   assign w_pop  = (r_count != 2'd0) && out_ready;
   assign w_push = (r_state == S_PUSH) && ((r_count != 2'd2) || w_pop);

   assign out_valid = (r_count != 2'd0);
   assign out_data  = out_valid ? r_mem[r_rd_ptr][7:0]  : 8'd0;
   assign out_slot  = out_valid ? r_mem[r_rd_ptr][10:8] : 3'd0;

   assign rom_req  = r_req;
   assign rom_addr = r_addr;
   assign rom_cs   = r_cs;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

   // Slot code registers; writes are accepted in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) r_code[i] <= 4'd15;
      end else if (slot_we) begin
         r_code[slot_idx] <= slot_code;
      end
   end

   // Fetch sequencer: walks the slots, issues ROM reads and hands rows to the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_slot    <= 3'd0;
         r_row     <= 6'd0;
         r_data    <= 8'd0;
         r_req     <= 1'b0;
         r_addr    <= '0;
         r_cs      <= 2'b00;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= line_start && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (line_start) begin
                  r_row   <= glyph_row;
                  r_slot  <= 3'd0;
                  r_busy  <= 1'b1;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (w_blank) begin
                  r_data  <= 8'h00;
                  r_state <= S_PUSH;
               end else begin
                  r_addr  <= w_addr;
                  r_cs    <= chip_sel;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (rom_ack) begin
                  r_data  <= rom_data;
                  r_req   <= 1'b0;
                  r_state <= S_PUSH;
               end
            end
            S_PUSH: begin
               if (w_push) begin
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_slot  <= r_slot + 3'd1;
                     r_state <= S_LOOKUP;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Two-entry FIFO of {slot, bitmap}; a full buffer accepts a push only alongside a pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= 11'd0;
         r_mem[1] <= 11'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {r_slot, r_data};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: tb/tb_glyph_fetch_sequencer.sv
// tb/tb_glyph_fetch_sequencer.sv - scoreboard bench for glyph_fetch_sequencer
module tb_glyph_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       slot_we = 1'b0;
   logic [2:0] slot_idx = 3'd0;
   logic [3:0] slot_code = 4'd0;
   logic       line_start = 1'b0;
   logic [5:0] glyph_row = 6'd0;
   logic [3:0] value_out;
   logic [9:0] point_y;
   logic [1:0] chip_sel;
   logic       rom_req;
   logic [9:0] rom_addr;
   logic [1:0] rom_cs;
   logic       rom_ack = 1'b0;
   logic [7:0] rom_data = 8'hEE;
   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] out_slot;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       overrun;

   int         n_vec = 0;
   int         n_err = 0;
   int         ack_delay = 0;
   logic [3:0] tb_code [0:7];
   logic [11:0] exp_addr [$];
   logic [10:0] exp_out [$];

   glyph_fetch_sequencer #(.SLOTS(8), .ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .slot_we(slot_we), .slot_idx(slot_idx), .slot_code(slot_code),
      .line_start(line_start), .glyph_row(glyph_row), .value_out(value_out), .point_y(point_y),
      .chip_sel(chip_sel), .rom_req(rom_req), .rom_addr(rom_addr), .rom_cs(rom_cs),
      .rom_ack(rom_ack), .rom_data(rom_data), .out_valid(out_valid), .out_data(out_data),
      .out_slot(out_slot), .out_ready(out_ready), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Pointer table model: digits are 60 rows tall, indicators 20 rows
   function automatic logic [11:0] ptab(input logic [3:0] c);
      case (c)
         4'd10:   return {2'b10, 10'd0};
         4'd11:   return {2'b10, 10'd20};
         4'd12:   return {2'b10, 10'd40};
         4'd13:   return {2'b11, 10'd0};
         4'd14:   return {2'b11, 10'd20};
         4'd15:   return {2'b00, 10'd0};
         default: return {2'b01, 10'(c * 60)};
      endcase
   endfunction

   function automatic logic [7:0] rom_model(input logic [9:0] a, input logic [1:0] cs);
      return 8'(a * 3) ^ {6'd0, cs} ^ 8'hA5;
   endfunction

   assign {chip_sel, point_y} = ptab(value_out);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ROM responder: acks after ack_delay held cycles, drives junk data outside the ack cycle
   initial begin
      int         req_cycles;
      logic [11:0] held;
      logic [11:0] e;
      req_cycles = 0;
      held = 12'd0;
      forever begin
         @(negedge clk);
         rom_ack  = 1'b0;
         rom_data = 8'hEE;
         if (rom_req) begin
            if (req_cycles == 0) begin
               held = {rom_cs, rom_addr};
               check("req_expected", 32'(exp_addr.size() != 0), 1);
               if (exp_addr.size() != 0) begin
                  e = exp_addr.pop_front();
                  check("rom_addr_cs", {rom_cs, rom_addr}, e);
               end
            end else begin
               check("req_addr_stable", {rom_cs, rom_addr}, held);
            end
            if (req_cycles == ack_delay) begin
               rom_ack    = 1'b1;
               rom_data   = rom_model(rom_addr, rom_cs);
               req_cycles = 0;
            end else begin
               req_cycles++;
            end
         end else begin
            req_cycles = 0;
         end
      end
   end

   // Output scoreboard: compares every popped entry against the expected queue
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid && out_ready) begin
            check("out_expected", 32'(exp_out.size() != 0), 1);
            if (exp_out.size() != 0) begin
               e = exp_out.pop_front();
               check("out_slot", out_slot, e[10:8]);
               check("out_data", out_data, e[7:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic write_slot(input int idx, input logic [3:0] c);
      @(negedge clk);
      slot_we = 1'b1; slot_idx = 3'(idx); slot_code = c;
      @(negedge clk);
      slot_we = 1'b0;
      tb_code[idx] = c;
   endtask

   task automatic start_pass(input logic [5:0] row);
      logic [11:0] p;
      logic [9:0]  a;
      logic        blank;
      for (int s = 0; s < 8; s++) begin
         p = ptab(tb_code[s]);
         blank = (p[11:10] == 2'b00) || (p[11] && row >= 6'd20) || (row >= 6'd60);
         if (blank) begin
            exp_out.push_back({3'(s), 8'h00});
         end else begin
            a = p[9:0] + 10'(row);
            exp_addr.push_back({p[11:10], a});
            exp_out.push_back({3'(s), rom_model(a, p[11:10])});
         end
      end
      @(negedge clk);
      line_start = 1'b1; glyph_row = row;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic wait_done();
      int done;
      done = 0;
      for (int i = 0; i < 600 && done == 0; i++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_out.size() == 0) done = 1;
      end
      check("pass_done", done, 1);
      check("addr_queue_empty", exp_addr.size(), 0);
   endtask

   initial begin
      int seen;
      int hi;
      for (int i = 0; i < 8; i++) tb_code[i] = 4'd15;

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rom_req", rom_req, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_rom_cs", rom_cs, 0);
      check("rst_value_out", value_out, 0);
      check("rst_overrun", overrun, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_slot", out_slot, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Mixed pass with latency checks
      write_slot(0, 4'd1);  write_slot(1, 4'd2);  write_slot(2, 4'd10); write_slot(3, 4'd3);
      write_slot(4, 4'd4);  write_slot(5, 4'd11); write_slot(6, 4'd13); write_slot(7, 4'd15);
      start_pass(6'd5);
      check("lat1_busy", busy, 1);
      check("lat1_rom_req", rom_req, 0);
      check("lat1_value_out", value_out, 1);
      @(negedge clk);
      check("lat2_rom_req", rom_req, 1);
      check("lat2_rom_addr", rom_addr, 65);
      @(negedge clk);
      check("lat3_rom_req", rom_req, 0);
      check("lat3_out_valid", out_valid, 0);
      @(negedge clk);
      check("lat4_out_valid", out_valid, 1);
      wait_done();

      // Row 59 on a digit, indicator row past its height
      write_slot(0, 4'd9);
      start_pass(6'd59);
      wait_done();
      write_slot(0, 4'd10);
      start_pass(6'd25);
      wait_done();

      // Delayed ack: request held with stable address for the wait
      ack_delay = 4;
      start_pass(6'd5);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (rom_req) seen = 1;
      end
      check("delay_req_seen", seen, 1);
      hi = 1;
      for (int i = 0; i < 20 && rom_req; i++) begin
         @(negedge clk);
         if (rom_req) hi++;
      end
      check("delay_req_len", hi, 5);
      wait_done();
      ack_delay = 0;

      // Consumer stalled for the whole pass
      out_ready = 1'b0;
      start_pass(6'd5);
      repeat (40) @(negedge clk);
      check("stall_busy", busy, 1);
      check("stall_out_valid", out_valid, 1);
      check("stall_head_slot", out_slot, 0);
      check("stall_rom_req", rom_req, 0);
      check("stall_queue_left", exp_out.size(), 8);
      out_ready = 1'b1;
      wait_done();

      // Second line_start during a pass
      start_pass(6'd5);
      @(negedge clk);
      @(negedge clk);
      line_start = 1'b1; glyph_row = 6'd30;
      @(negedge clk);
      line_start = 1'b0;
      check("overrun_pulse", overrun, 1);
      @(negedge clk);
      check("overrun_clear", overrun, 0);
      wait_done();

      // Reset while a request is outstanding
      ack_delay = 10;
      start_pass(6'd5);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (rom_req) seen = 1;
      end
      check("rstreq_req_seen", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstreq_rom_req", rom_req, 0);
      check("rstreq_busy", busy, 0);
      check("rstreq_out_valid", out_valid, 0);
      exp_addr.delete();
      exp_out.delete();
      for (int i = 0; i < 8; i++) tb_code[i] = 4'd15;
      ack_delay = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      start_pass(6'd7);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
